spi_slave_cpol0_cpha0: RTL and testbench

SPI mode-0 (CPOL=0, CPHA=0) responder. It is the peer of the team's spi_master_cpol0_cpha0.
- Oversamples the external sclk, mosi and cs_n inputs in the local clk domain.
- Shifts in one MSB-first byte per frame slot and presents it with a one-cycle valid strobe.
- Shifts out a byte supplied over a valid/ready handshake.
- Sits between the board-level SPI pins and the local byte consumer/producer, such as a command decoder.

---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_sync_edge.sv | 31 +++
 rtl/spi_slave_cpol0_cpha0.sv | 158 +++++++++++++++
 tb/tb_spi_slave_cpol0_cpha0.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI word width, fill byte default and responder state encoding
package spi_pkg;

  localparam int SPI_WORD_W = 8;
  localparam int SPI_CNT_W  = $clog2(SPI_WORD_W);
  localparam logic [SPI_WORD_W-1:0] FILL_BYTE_DEF = 8'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchronizer with rise/fall detect on the synchronized level
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
      r_prev <= RESET_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_sync = r_sync[SYNC_STAGES-1];
  assign o_rise = o_sync & ~r_prev;
  assign o_fall = ~o_sync & r_prev;

endmodule

// File: rtl/spi_slave_cpol0_cpha0.sv
// rtl/spi_slave_cpol0_cpha0.sv - SPI mode-0 responder with single-byte tx holding buffer
// Define SPI_SLAVE_OVERRUN_EN to add rx_ack/rx_overrun sticky overrun tracking.
module spi_slave_cpol0_cpha0
  import spi_pkg::*;
#(
  parameter int                    SYNC_STAGES = 2,
  parameter logic [SPI_WORD_W-1:0] FILL_BYTE   = FILL_BYTE_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [SPI_WORD_W-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [SPI_WORD_W-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy
`ifdef SPI_SLAVE_OVERRUN_EN
  ,
  input  logic                  rx_ack,
  output logic                  rx_overrun
`endif
);

  spi_state_t r_state, w_state_nxt;

  logic                  w_sclk_s, w_sclk_rise, w_sclk_fall;
  logic                  w_cs_s, w_cs_rise, w_cs_fall;
  logic                  w_mosi_s, w_unused_edges;
  logic [SYNC_STAGES-1:0] r_mosi_sync;

  logic [SPI_WORD_W-1:0] r_buf, r_tx_shift, r_rx_shift, r_rx_data;
  logic                  r_buf_full, r_miso, r_miso_oe, r_rx_valid;
  logic [SPI_CNT_W-1:0]  r_bit_cnt;
  logic                  w_wr, w_load;
  logic [SPI_WORD_W-1:0] w_load_byte;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .i_async(sclk),
    .o_sync(w_sclk_s), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .i_async(cs_n),
    .o_sync(w_cs_s), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  // mosi shares the sclk synchronizer depth so sampled data lines up with the detected rise
  always_ff @(posedge clk) begin
    if (rst) r_mosi_sync <= '0;
    else     r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
  end
  assign w_mosi_s       = r_mosi_sync[SYNC_STAGES-1];
  assign w_unused_edges = &{1'b0, w_sclk_s, w_cs_rise};

  assign w_wr        = tx_valid & ~r_buf_full;
  assign w_load      = (r_state == LOAD) ||
                       ((r_state == SHIFT) && !w_cs_s && w_sclk_fall && (r_bit_cnt == '0));
  assign w_load_byte = r_buf_full ? r_buf : FILL_BYTE;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_cs_fall) w_state_nxt = LOAD;
      LOAD:    w_state_nxt = SHIFT;
      SHIFT:   if (w_cs_s) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf      <= '0;
      r_buf_full <= 1'b0;
      r_tx_shift <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_bit_cnt  <= '0;
      r_miso     <= 1'b0;
      r_miso_oe  <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      // a write landing with a load is kept for the following byte
      if (w_wr) begin
        r_buf      <= tx_data;
        r_buf_full <= 1'b1;
      end else if (w_load) begin
        r_buf_full <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          r_bit_cnt <= '0;
          r_miso_oe <= 1'b0;
        end
        SHIFT: begin
          if (w_cs_s) begin
            r_bit_cnt <= '0;
            r_miso_oe <= 1'b0;
          end else if (w_sclk_rise) begin
            r_rx_shift <= {r_rx_shift[SPI_WORD_W-2:0], w_mosi_s};
            r_bit_cnt  <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == SPI_CNT_W'(SPI_WORD_W - 1)) begin
              r_rx_data  <= {r_rx_shift[SPI_WORD_W-2:0], w_mosi_s};
              r_rx_valid <= 1'b1;
            end
          end else if (w_sclk_fall && (r_bit_cnt != '0)) begin
            r_tx_shift <= {r_tx_shift[SPI_WORD_W-2:0], 1'b0};
            r_miso     <= r_tx_shift[SPI_WORD_W-2];
          end
        end
        default: ;
      endcase
      if (w_load) begin
        r_tx_shift <= w_load_byte;
        r_miso     <= w_load_byte[SPI_WORD_W-1];
        r_miso_oe  <= 1'b1;
      end
    end
  end

  assign miso     = r_miso;
  assign miso_oe  = r_miso_oe;
  assign tx_ready = ~r_buf_full;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign busy     = (r_state != IDLE);

`ifdef SPI_SLAVE_OVERRUN_EN
  logic r_rx_pending, r_rx_overrun;

  // ack in the strobe cycle itself counts for the byte being strobed
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_pending <= 1'b0;
      r_rx_overrun <= 1'b0;
    end else begin
      if (r_rx_valid)  r_rx_pending <= ~rx_ack;
      else if (rx_ack) r_rx_pending <= 1'b0;
      if (r_rx_valid && r_rx_pending) r_rx_overrun <= 1'b1;
    end
  end

  assign rx_overrun = r_rx_overrun;
`else
  // no overrun tracking in this build
`endif

endmodule

// File: tb/tb_spi_slave_cpol0_cpha0.sv
// tb/tb_spi_slave_cpol0_cpha0.sv - directed table-driven bench for the SPI mode-0 responder
module tb_spi_slave_cpol0_cpha0;

  localparam int SYNC = 2;
  localparam int HALF = 8;

  logic       clk = 1'b0, rst = 1'b1, sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       miso, miso_oe, tx_ready, rx_valid, busy;
  logic [7:0] rx_data;
`ifdef SPI_SLAVE_OVERRUN_EN
  logic       rx_ack = 1'b0;
  logic       rx_overrun;
`endif

  always #5 clk = ~clk;

  spi_slave_cpol0_cpha0 #(.SYNC_STAGES(SYNC), .FILL_BYTE(8'h00)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
`ifdef SPI_SLAVE_OVERRUN_EN
    , .rx_ack(rx_ack), .rx_overrun(rx_overrun)
`endif
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         rise_cyc = 0;
  logic [7:0] rx_q[$];
  int         lat_q[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_q.push_back(rx_data);
      lat_q.push_back(cyc - rise_cyc);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_xfer(input logic [7:0] mo, input int nbits,
                          output logic [7:0] mi, output logic oe_ok);
    mi    = 8'h00;
    oe_ok = 1'b1;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = mo[i];
      tick(HALF);
      sclk     = 1'b1;
      rise_cyc = cyc;
      mi[i]    = miso;
      oe_ok    = oe_ok & miso_oe;
      tick(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic tx_write(input logic [7:0] d);
    int n = 0;
    while (!tx_ready && n < 100) begin
      tick(1);
      n++;
    end
    check("tx_ready_wait_in_budget", 32'(n < 100), 1);
    tx_data  = d;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    check("tx_ready_low_after_write", tx_ready, 0);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
  endtask

  typedef struct {
    logic [7:0] tx;
    logic [7:0] mo;
    logic [7:0] exp_rx;
    logic [7:0] exp_mi;
  } vec_t;

  vec_t       vt[4];
  logic [7:0] mi, mi0, mi1, mi2;
  logic       oe_ok;
  int         n;

  initial begin
    vt[0] = '{tx: 8'hA5, mo: 8'h3C, exp_rx: 8'h3C, exp_mi: 8'hA5};
    vt[1] = '{tx: 8'h00, mo: 8'hFF, exp_rx: 8'hFF, exp_mi: 8'h00};
    vt[2] = '{tx: 8'hFF, mo: 8'h00, exp_rx: 8'h00, exp_mi: 8'hFF};
    vt[3] = '{tx: 8'h96, mo: 8'h69, exp_rx: 8'h69, exp_mi: 8'h96};

    // reset state with cs_n high
    tick(4);
    rst = 1'b0;
    tick(1);
    check("rst_miso_oe", miso_oe, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_miso", miso, 0);
    tick(20);
    check("rst_no_rx_valid", rx_q.size(), 0);

    // single-byte frames
    for (int i = 0; i < 4; i++) begin
      rx_q.delete();
      lat_q.delete();
      tx_write(vt[i].tx);
      cs_n = 1'b0;
      tick(HALF);
      check("vec_tx_ready_after_load", tx_ready, 1);
      check("vec_busy_in_frame", busy, 1);
      check("vec_miso_first_bit", miso, vt[i].exp_mi[7]);
      spi_xfer(vt[i].mo, 8, mi, oe_ok);
      tick(HALF);
      cs_n = 1'b1;
      tick(HALF);
      check("vec_rx_count", rx_q.size(), 1);
      check("vec_rx_data", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, vt[i].exp_rx);
      check("vec_rx_latency", (lat_q.size() > 0) ? lat_q[0] : -1, SYNC + 1);
      check("vec_master_rx", mi, vt[i].exp_mi);
      check("vec_miso_oe_during", oe_ok, 1);
      check("vec_busy_after", busy, 0);
      check("vec_miso_oe_after", miso_oe, 0);
    end

    // three bytes in one frame; second tx byte written after the first load
    rx_q.delete();
    tx_write(8'h10);
    cs_n = 1'b0;
    tick(6);
    tx_write(8'h20);
    spi_xfer(8'h01, 8, mi0, oe_ok);
    spi_xfer(8'h02, 8, mi1, oe_ok);
    spi_xfer(8'h03, 8, mi2, oe_ok);
    tick(HALF);
    cs_n = 1'b1;
    tick(HALF);
    check("b2b_rx_count", rx_q.size(), 3);
    check("b2b_rx0", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'h01);
    check("b2b_rx1", (rx_q.size() > 1) ? rx_q[1] : 8'hxx, 8'h02);
    check("b2b_rx2", (rx_q.size() > 2) ? rx_q[2] : 8'hxx, 8'h03);
    check("b2b_mi0", mi0, 8'h10);
    check("b2b_mi1", mi1, 8'h20);
    check("b2b_mi2_fill", mi2, 8'h00);
    check("b2b_tx_ready_end", tx_ready, 1);

    // cs_n aborts a partial byte
    rx_q.delete();
    cs_n = 1'b0;
    tick(HALF);
    spi_xfer(8'hFF, 5, mi, oe_ok);
    cs_n = 1'b1;
    n = 0;
    while (miso_oe && n < 20) begin
      tick(1);
      n++;
    end
    check("abort_oe_drop_cycles_ok", 32'(n <= SYNC + 1), 1);
    tick(2 * HALF);
    check("abort_no_rx_valid", rx_q.size(), 0);
    cs_n = 1'b0;
    tick(HALF);
    spi_xfer(8'h81, 8, mi, oe_ok);
    tick(HALF);
    cs_n = 1'b1;
    tick(HALF);
    check("abort_next_rx_count", rx_q.size(), 1);
    check("abort_next_rx", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'h81);
    check("abort_next_mi_fill", mi, 8'h00);

    // reset after three bits of a byte
    rx_q.delete();
    tx_write(8'hFF);
    cs_n = 1'b0;
    tick(HALF);
    tx_write(8'h99);
    spi_xfer(8'hC3, 3, mi, oe_ok);
    tick(HALF);
    check("pre_rst_miso", miso, 1);
    rst = 1'b1;
    tick(1);
    rst  = 1'b0;
    cs_n = 1'b1;
    check("mid_rst_miso", miso, 0);
    check("mid_rst_miso_oe", miso_oe, 0);
    check("mid_rst_tx_ready", tx_ready, 1);
    check("mid_rst_rx_data", rx_data, 8'h00);
    check("mid_rst_rx_valid", rx_valid, 0);
    check("mid_rst_busy", busy, 0);
    tick(HALF);
    tx_write(8'h6E);
    cs_n = 1'b0;
    tick(HALF);
    spi_xfer(8'h42, 8, mi, oe_ok);
    tick(HALF);
    cs_n = 1'b1;
    tick(HALF);
    check("post_rst_rx_count", rx_q.size(), 1);
    check("post_rst_rx", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'h42);
    check("post_rst_mi", mi, 8'h6E);

`ifdef SPI_SLAVE_OVERRUN_EN
    pulse_rst();
    check("ovr_after_rst", rx_overrun, 0);
    rx_ack = 1'b0;
    cs_n = 1'b0;
    tick(HALF);
    spi_xfer(8'h11, 8, mi, oe_ok);
    spi_xfer(8'h22, 8, mi, oe_ok);
    tick(HALF);
    cs_n = 1'b1;
    tick(HALF);
    check("ovr_set_no_ack", rx_overrun, 1);
    tick(20);
    check("ovr_sticky", rx_overrun, 1);
    pulse_rst();
    rx_ack = 1'b1;
    cs_n = 1'b0;
    tick(HALF);
    spi_xfer(8'h33, 8, mi, oe_ok);
    spi_xfer(8'h44, 8, mi, oe_ok);
    tick(HALF);
    cs_n = 1'b1;
    tick(HALF);
    check("ovr_clear_with_ack", rx_overrun, 0);
    rx_ack = 1'b0;
`else
    pulse_rst();
    check("final_rst_busy", busy, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
